// File: rtl/icache_set_assoc.sv
// Set-associative L1 instruction cache: same-cycle hits, sequential line refill,
// per-set round-robin replacement and a one-set-per-cycle invalidate sweep.
module icache_set_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_re,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic                  o_hit,
  output logic                  o_busy,
  input  logic                  i_invalidate,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_re,
  input  logic                  i_mem_busy,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(BYTES);
  localparam int WORD_W     = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(SETS);
  localparam int TAG_W      = ADDR_WIDTH - IDX_W - WORD_W - OFF_W;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_BYTES = BYTES * LINE_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_FLUSH} state_e;

  state_e                state_q, state_d;
  logic                  pend_q;
  logic [WORD_W-1:0]     word_cnt_q;
  logic [IDX_W-1:0]      flush_cnt_q;
  logic                  mem_re_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WAY_W-1:0]      victim_q;
  logic [IDX_W-1:0]      ref_idx_q;
  logic [TAG_W-1:0]      ref_tag_q;
  logic                  valid_q [WAYS][SETS];
  logic [WAY_W-1:0]      rr_q    [SETS];
  logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS][LINE_WORDS];

  logic [TAG_W-1:0]      lk_tag;
  logic [IDX_W-1:0]      lk_idx;
  logic [WORD_W-1:0]     lk_word;
  logic [ADDR_WIDTH-1:0] lk_base;
  logic [WAY_W-1:0]      lk_victim;
  logic                  hit_any;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  lookup_miss;
  logic                  beat_ok;
  logic                  last_beat;

  assign lk_tag      = i_addr[ADDR_WIDTH-1 -: TAG_W];
  assign lk_idx      = i_addr[OFF_W+WORD_W +: IDX_W];
  assign lk_word     = i_addr[OFF_W +: WORD_W];
  assign lk_base     = i_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
  assign lk_victim   = (WAYS > 1) ? rr_q[lk_idx] : '0;
  assign lookup_miss = (state_q == S_IDLE) && i_re && !i_invalidate && !hit_any;
  assign beat_ok     = (state_q == S_REFILL) && !i_mem_busy;
  assign last_beat   = (word_cnt_q == WORD_W'(LINE_WORDS - 1));

  // Refill never installs a tag already present, so at most one way matches.
  always_comb begin
    hit_any  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][lk_idx] && (tag_q[w][lk_idx] == lk_tag)) begin
        hit_any  = 1'b1;
        hit_data = data_q[w][lk_idx][lk_word];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_invalidate)     state_d = S_FLUSH;
        else if (lookup_miss) state_d = S_REFILL;
      end
      S_REFILL: begin
        if (beat_ok && last_beat) state_d = (pend_q || i_invalidate) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (flush_cnt_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_hit      = (state_q == S_IDLE) && i_re && !i_invalidate && hit_any;
    o_busy     = (state_q != S_IDLE) || (i_re && !o_hit) || i_invalidate;
    o_inst     = o_hit ? hit_data : '0;
    o_mem_re   = mem_re_q;
    o_mem_addr = mem_addr_q;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pend_q      <= 1'b0;
      word_cnt_q  <= '0;
      flush_cnt_q <= '0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      victim_q    <= '0;
      ref_idx_q   <= '0;
      ref_tag_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lookup_miss) begin
            victim_q                  <= lk_victim;
            ref_idx_q                 <= lk_idx;
            ref_tag_q                 <= lk_tag;
            valid_q[lk_victim][lk_idx] <= 1'b0;
            mem_re_q                  <= 1'b1;
            mem_addr_q                <= lk_base;
            word_cnt_q                <= '0;
          end
        end
        S_REFILL: begin
          if (i_invalidate) pend_q <= 1'b1;
          if (beat_ok) begin
            word_cnt_q <= word_cnt_q + WORD_W'(1);
            if (last_beat) begin
              valid_q[victim_q][ref_idx_q] <= 1'b1;
              rr_q[ref_idx_q]              <= (WAYS > 1) ? victim_q + WAY_W'(1) : '0;
              mem_re_q                     <= 1'b0;
              pend_q                       <= 1'b0;
            end else begin
              mem_addr_q <= mem_addr_q + ADDR_WIDTH'(BYTES);
            end
          end
        end
        S_FLUSH: begin
          rr_q[flush_cnt_q] <= '0;
          for (int w = 0; w < WAYS; w++) valid_q[w][flush_cnt_q] <= 1'b0;
          flush_cnt_q <= flush_cnt_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge i_clock) begin
    if (beat_ok) begin
      data_q[victim_q][ref_idx_q][word_cnt_q] <= i_mem_rdata;
      if (last_beat) tag_q[victim_q][ref_idx_q] <= ref_tag_q;
    end
  end
endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc with a behavioural instruction memory.
module tb_icache_set_assoc;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr;
  logic        i_re;
  logic [31:0] o_inst;
  logic        o_hit;
  logic        o_busy;
  logic        i_invalidate;
  logic [31:0] o_mem_addr;
  logic        o_mem_re;
  logic        i_mem_busy;
  logic [31:0] i_mem_rdata;

  int n_chk = 0;
  int n_fail = 0;
  logic wait_en = 1'b0;
  int   wcnt = 0;

  icache_set_assoc dut (
    .i_clock(clk), .i_reset(rst), .i_addr(i_addr), .i_re(i_re),
    .o_inst(o_inst), .o_hit(o_hit), .o_busy(o_busy), .i_invalidate(i_invalidate),
    .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re), .i_mem_busy(i_mem_busy),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  // Memory: optional 3 wait cycles before each accepted beat.
  assign i_mem_busy  = wait_en && o_mem_re && (wcnt != 3);
  assign i_mem_rdata = mw(o_mem_addr);
  always @(posedge clk) begin
    if (!o_mem_re || !i_mem_busy) wcnt <= 0;
    else                          wcnt <= wcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, output int nbusy, output logic [31:0] inst,
                       output int beats, output int aerr);
    logic [31:0] base;
    bit done;
    base = a & ~32'hF; nbusy = 0; beats = 0; aerr = 0; inst = '0; done = 0;
    i_addr = a; i_re = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (o_mem_re) begin
        if (o_mem_addr !== base + 32'(beats * 4)) aerr++;
        if (!i_mem_busy) beats++;
      end
      if (o_busy) nbusy++;
      if (o_hit) begin inst = o_inst; done = 1; end
      @(posedge clk); #1;
    end
    i_re = 1'b0;
    if (!done) nbusy = -1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!o_busy) begin @(posedge clk); #1; return; end
      n++;
      @(posedge clk); #1;
    end
    n = -1;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          exp_busy;
    int          exp_beats;
  } vec_t;
  vec_t vecs [12];

  initial begin
    int nb, bt, ae, n, k;
    logic [31:0] inst;
    logic [31:0] got [8];
    bit done;

    vecs[0]  = '{32'h0000_0100, 5, 4};
    vecs[1]  = '{32'h0000_0108, 0, 0};
    vecs[2]  = '{32'h0000_0104, 0, 0};
    vecs[3]  = '{32'h0000_010C, 0, 0};
    vecs[4]  = '{32'h0000_0000, 5, 4};
    vecs[5]  = '{32'h0000_0400, 5, 4};
    vecs[6]  = '{32'h0000_0800, 5, 4};
    vecs[7]  = '{32'h0000_0404, 0, 0};
    vecs[8]  = '{32'h0000_0000, 5, 4};
    vecs[9]  = '{32'h0000_0800, 0, 0};
    vecs[10] = '{32'h0000_0400, 5, 4};
    vecs[11] = '{32'h0000_0008, 0, 0};

    rst = 1'b1; i_addr = '0; i_re = 1'b0; i_invalidate = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hit", 32'(o_hit), 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_mem_re", 32'(o_mem_re), 0);
    chk("reset_mem_addr", o_mem_addr, 0);
    chk("reset_inst", o_inst, 0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      fetch(vecs[i].addr, nb, inst, bt, ae);
      chk($sformatf("vec%0d_busy", i), 32'(nb), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_inst", i), inst, mw(vecs[i].addr));
      chk($sformatf("vec%0d_beats", i), 32'(bt), 32'(vecs[i].exp_beats));
      chk($sformatf("vec%0d_addr_seq", i), 32'(ae), 0);
    end

    // Idle with i_re=0 on a resident line: no lookup, no stall.
    i_addr = 32'h100;
    @(negedge clk);
    chk("idle_nore_hit", 32'(o_hit), 0);
    chk("idle_nore_busy", 32'(o_busy), 0);
    @(posedge clk); #1;

    wait_en = 1'b1;
    fetch(32'h300, nb, inst, bt, ae);
    chk("wait_busy", 32'(nb), 17);
    chk("wait_inst", inst, mw(32'h300));
    chk("wait_addr_held", 32'(ae), 0);
    wait_en = 1'b0;
    fetch(32'h30C, nb, inst, bt, ae);
    chk("wait_hit_busy", 32'(nb), 0);
    chk("wait_hit_inst", inst, mw(32'h30C));

    // Invalidate together with a fetch of a resident line.
    i_addr = 32'h100; i_re = 1'b1; i_invalidate = 1'b1;
    @(negedge clk);
    chk("inv_re_hit", 32'(o_hit), 0);
    chk("inv_re_busy", 32'(o_busy), 1);
    @(posedge clk); #1;
    i_invalidate = 1'b0; i_re = 1'b0;
    count_busy(n);
    chk("flush_busy_cycles", 32'(n + 1), 65);
    fetch(32'h100, nb, inst, bt, ae);
    chk("after_flush_miss", 32'(nb), 5);
    chk("after_flush_inst", inst, mw(32'h100));

    // Invalidate on the second refill beat.
    i_addr = 32'h500; i_re = 1'b1;
    @(negedge clk);
    chk("inv_refill_miss_busy", 32'(o_busy), 1);
    @(posedge clk); #1;
    i_re = 1'b0;
    @(posedge clk); #1;
    i_invalidate = 1'b1;
    @(posedge clk); #1;
    i_invalidate = 1'b0;
    count_busy(n);
    chk("inv_refill_busy_total", 32'(n + 3), 69);
    fetch(32'h500, nb, inst, bt, ae);
    chk("inv_refill_refetch_miss", 32'(nb), 5);
    chk("inv_refill_refetch_inst", inst, mw(32'h500));

    // Reset after two refill beats.
    i_addr = 32'h600; i_re = 1'b1;
    @(posedge clk); #1;
    i_re = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_hit", 32'(o_hit), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_mem_re", 32'(o_mem_re), 0);
    chk("midrst_mem_addr", o_mem_addr, 0);
    chk("midrst_inst", o_inst, 0);
    @(posedge clk); #1;
    fetch(32'h600, nb, inst, bt, ae);
    chk("midrst_refetch_busy", 32'(nb), 5);
    chk("midrst_refetch_beats", 32'(bt), 4);
    chk("midrst_refetch_inst", inst, mw(32'h600));

    // Address moves from 0x100 to 0x200 while the 0x100 line refills.
    i_addr = 32'h100; i_re = 1'b1; k = 0; nb = 0; done = 0; inst = '0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (o_mem_re && !i_mem_busy && k < 8) begin got[k] = o_mem_addr; k++; end
      if (o_busy) nb++;
      if (o_hit) begin inst = o_inst; done = 1; end
      @(posedge clk); #1;
      if (c == 0) i_addr = 32'h200;
    end
    i_re = 1'b0;
    chk("chg_busy", 32'(nb), 10);
    chk("chg_beats", 32'(k), 8);
    chk("chg_inst", inst, mw(32'h200));
    for (int j = 0; j < 8; j++) begin
      logic [31:0] exp_a;
      exp_a = ((j < 4) ? 32'h100 : 32'h200) + 32'((j % 4) * 4);
      chk($sformatf("chg_mem_addr%0d", j), (j < k) ? got[j] : 32'hFFFF_FFFF, exp_a);
    end
    fetch(32'h104, nb, inst, bt, ae);
    chk("chg_hit100_busy", 32'(nb), 0);
    chk("chg_hit100_inst", inst, mw(32'h104));
    fetch(32'h20C, nb, inst, bt, ae);
    chk("chg_hit200_busy", 32'(nb), 0);
    chk("chg_hit200_inst", inst, mw(32'h20C));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_set_assoc.md
# icache_set_assoc

Parametrised, set-associative L1 instruction cache. It replaces the fixed direct-mapped instruction cache between the core fetch stage and the L2 cache or main-memory instruction port. Hits return in the same cycle. Misses refill a whole line with sequential single-word reads, using per-set round-robin replacement. An explicit invalidate sweeps all sets.

## Interface
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: instruction word width; multiple of 8.
- WAYS, 2: associativity; power of two, ≥1.
- SETS, 64: sets per way; power of two, ≥2.
- LINE_WORDS, 4: words per line; power of two, ≥2.

- i_clock  in  1  clock; single clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_addr  in  ADDR_WIDTH  core fetch byte address (word aligned).
- i_re  in  1  core fetch request.
- o_inst  out  DATA_WIDTH  instruction; valid when o_hit=1, else 0.
- o_hit  out  1  lookup hit this cycle.
- o_busy  out  1  core must stall and hold i_addr.
- i_invalidate  in  1  one-cycle pulse: invalidate whole cache.
- o_mem_addr  out  ADDR_WIDTH  memory read byte address.
- o_mem_re  out  1  memory read request.
- i_mem_busy  in  1  memory not ready; while 1, request is not accepted.
- i_mem_rdata  in  DATA_WIDTH  read data; valid in any cycle with o_mem_re=1 and i_mem_busy=0.

## Operation
- Address split, LSB first:
  - byte offset: log2(DATA_WIDTH/8) bits.
  - word offset: log2(LINE_WORDS) bits.
  - index: log2(SETS) bits.
  - tag: the remaining bits.
- Storage:
  - per way/set: valid bit, tag, LINE_WORDS data words.
  - per set: round-robin victim pointer, log2(WAYS) bits (0 bits when WAYS=1).
- FSM states: IDLE, REFILL, FLUSH.
- IDLE:
  - hit = i_re, plus a valid way with matching tag at the index.
  - o_inst is driven combinationally from the matching way.
  - At most one way can match; this is guaranteed by construction because refill never installs a tag that is already present.
- Miss (i_re=1, no hit, IDLE):
  - Latch the line base address (word and byte offset zeroed) and the victim way from the set pointer.
  - Clear the victim's valid bit.
  - Go to REFILL.
- REFILL:
  - o_mem_re=1; o_mem_addr = line base + word_cnt·(DATA_WIDTH/8).
  - Each accepted beat writes i_mem_rdata into the victim at word_cnt, then word_cnt increments.
  - On the last beat: write the tag, set valid, advance the set pointer (modulo WAYS, wrapping), return to IDLE.
- FLUSH:
  - Clears the valid bits of one set per cycle, counting from set 0 to SETS-1, then returns to IDLE.
  - Replacement pointers are also reset to 0.
- o_busy = (state≠IDLE) | (i_re & ~hit) | i_invalidate. o_hit is forced to 0 outside IDLE.
- Boundary rules:
  - **i_addr changes during REFILL:** the refill runs to completion; the new address is looked up afterwards.
  - **i_invalidate during REFILL:** latched in a pending flag; FLUSH starts immediately after the refill finishes.
  - **i_invalidate with i_re in IDLE:** invalidate wins; go to FLUSH with no lookup.
  - **i_invalidate during FLUSH:** ignored.
  - **i_re=0:** no lookup, o_busy=0 in IDLE, no state change.
  - **Reset:** wins over everything, including mid-refill and mid-flush. It clears all valid bits and pointers in one cycle; a partially filled line stays invalid.

## Timing
- Reset values: o_hit=0, o_busy=0, o_mem_re=0, o_mem_addr=0, o_inst=0; state IDLE, pending flag 0, counters 0.
- Hit: zero latency; o_inst, o_hit and o_busy=0 are all in the same cycle as i_re.
- Miss, zero-wait memory:
  - cycle 0: lookup misses, o_busy=1.
  - cycles 1..LINE_WORDS: REFILL beats.
  - cycle LINE_WORDS+1: hit, o_busy=0.
- Each cycle with i_mem_busy=1 adds one cycle. o_mem_addr and o_mem_re are held stable while busy.
- Flush: o_busy=1 for SETS+1 cycles (pulse cycle plus SETS sweep cycles).
- All outputs except o_inst, o_hit and o_busy are registered.

## Test plan
- **Cold miss (WAYS=2, LINE_WORDS=4, zero-wait memory):** fetch 0x100.
  - o_mem_addr steps 0x100, 0x104, 0x108, 0x10C.
  - o_busy is high for 5 cycles.
  - Fetching 0x108 then hits immediately with the third returned word.
- **Wait states:** i_mem_busy=1 for 3 cycles on each beat. Address held; busy lasts 17 cycles; data is correct.
- **Round robin (SETS=64, line 16 B):** fetch 0x0000, 0x0400, 0x0800 (same set).
  - 0x0800 evicts way 0 (0x0000).
  - Refetching 0x0400 hits; 0x0000 misses and evicts way 1.
- **Invalidate during REFILL, beat 2:**
  - The refill completes, then FLUSH runs for 64 cycles.
  - The next fetch of the same address misses.
- **Reset mid-refill after 2 beats:**
  - All outputs return to their reset values in the following cycle.
  - The refetch misses and issues the full 4-beat refill.
- **Address change mid-refill (0x100 → 0x200):** the 0x100 line completes, then the 0x200 miss refills; both lines then hit.
